// File: rtl/flow_control_ack_gen.sv
// flow_control_ack_gen
//   Downstream end of the flow-control loop. Counts flits consumed from the
//   local input buffer and injects a single-flit UDP ACK carrying the running
//   consumed-flit total into the outgoing 512-bit stream, only at packet
//   boundaries. Every other flit passes through unchanged with one cycle of
//   latency.
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   consumed                         one-cycle pulse per consumed flit
//   in_data/sop/eop/empty/valid      upstream Avalon-ST stream
//   in_ready                         upstream may advance (0 while rst=1)
//   out_data/sop/eop/empty/valid     merged stream towards the MAC
//   out_ready                        downstream accepts the out_* flit
//   ack_sent_cnt                     number of ACK packets emitted (wraps)
// ACK flit layout (all unlisted bits zero)
//   [415:400] eth_type 0x0800   [399:392] version 4 / ihl 5
//   [327:320] ip protocol 17    [239:224] udp sport  [223:208] udp dport
//   [175:144] ack data = consumed-flit total snapshot (first payload word)
// TOTAL_RST is the reset value of both the total and the last-sent marker;
// it lets the wrap-around path be exercised without 2^32 pulses.
module flow_control_ack_gen #(
  parameter int unsigned      ACK_INTERVAL = 256,
  parameter int unsigned      ACK_DELTA    = 64,
  parameter int unsigned      CNT_W        = 32,
  parameter logic [15:0]      ACK_PKT_PORT = 16'hAC00,
  parameter logic [CNT_W-1:0] TOTAL_RST    = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         consumed,
  input  logic [511:0] in_data,
  input  logic         in_sop,
  input  logic         in_eop,
  input  logic [5:0]   in_empty,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] out_data,
  output logic         out_sop,
  output logic         out_eop,
  output logic [5:0]   out_empty,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  ack_sent_cnt
);

  localparam int unsigned TIMER_W = $clog2(ACK_INTERVAL + 1);
  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_PKT  = 1'b1;

  logic [0:0]       state_q,     state_d;
  logic [CNT_W-1:0] total_q,     total_d;
  logic [CNT_W-1:0] last_sent_q, last_sent_d;
  logic [TIMER_W-1:0] timer_q,   timer_d;
  logic             out_valid_q, out_valid_d;
  logic [511:0]     out_data_q,  out_data_d;
  logic             out_sop_q,   out_sop_d;
  logic             out_eop_q,   out_eop_d;
  logic [5:0]       out_empty_q, out_empty_d;
  logic [31:0]      ack_cnt_q,   ack_cnt_d;

  logic             slot_free;
  logic [CNT_W-1:0] delta;
  logic [CNT_W-1:0] snapshot;
  logic             ack_req;
  logic             ack_load;
  logic             in_ready_int;
  logic             accept;

  function automatic logic [511:0] build_ack(input logic [CNT_W-1:0] value);
    logic [511:0] flit;
    flit            = '0;
    flit[415:400]   = 16'h0800;
    flit[399:392]   = 8'h45;
    flit[327:320]   = 8'd17;
    flit[239:224]   = ACK_PKT_PORT;
    flit[223:208]   = ACK_PKT_PORT;
    flit[175:144]   = 32'(value);
    return flit;
  endfunction

  assign slot_free    = ~out_valid_q | out_ready;
  assign delta        = total_q - last_sent_q;
  // The snapshot includes this cycle's pulse so the ACK is never one behind.
  assign snapshot     = total_q + CNT_W'(consumed);
  assign ack_req      = (delta >= CNT_W'(ACK_DELTA)) |
                        ((timer_q == TIMER_W'(ACK_INTERVAL)) & (delta != '0));
  // ACKs only go out between packets, and win over a waiting sop.
  assign ack_load     = (state_q == ST_IDLE) & ack_req & slot_free;
  assign in_ready_int = slot_free & ~ack_load;
  assign accept       = in_valid & in_ready_int;
  assign in_ready     = in_ready_int & ~rst;

  always_comb begin
    state_d     = state_q;
    total_d     = snapshot;
    last_sent_d = last_sent_q;
    timer_d     = timer_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_empty_d = out_empty_q;
    ack_cnt_d   = ack_cnt_q;

    if (ack_load) begin
      out_valid_d = 1'b1;
      out_data_d  = build_ack(snapshot);
      out_sop_d   = 1'b1;
      out_eop_d   = 1'b1;
      out_empty_d = 6'd0;
      last_sent_d = snapshot;
      timer_d     = '0;
      ack_cnt_d   = ack_cnt_q + 32'd1;
    end else begin
      if ((delta != '0) && (timer_q != TIMER_W'(ACK_INTERVAL))) begin
        timer_d = timer_q + TIMER_W'(1);
      end
      if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_sop_d   = in_sop;
        out_eop_d   = in_eop;
        out_empty_d = in_empty;
        if ((state_q == ST_IDLE) && in_sop && !in_eop) begin
          state_d = ST_PKT;
        end else if ((state_q == ST_PKT) && in_eop) begin
          state_d = ST_IDLE;
        end
      end else if (slot_free) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      total_q     <= TOTAL_RST;
      last_sent_q <= TOTAL_RST;
      timer_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= 6'd0;
      ack_cnt_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      last_sent_q <= last_sent_d;
      timer_q     <= timer_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_empty_q <= out_empty_d;
      ack_cnt_q   <= ack_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_sop      = out_sop_q;
  assign out_eop      = out_eop_q;
  assign out_empty    = out_empty_q;
  assign ack_sent_cnt = ack_cnt_q;

endmodule
